// File: rtl/uart_tx_if.sv
// Host-side byte push channel and serial-line status of the UART transmitter.
interface uart_tx_if;
    logic       i_Tx_Valid;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Ready;
    logic       o_Tx_Serial;
    logic       o_Tx_Active;
    logic       o_Tx_Done;

    modport master (
        output i_Tx_Valid,
        output i_Tx_Byte,
        input  o_Tx_Ready,
        input  o_Tx_Serial,
        input  o_Tx_Active,
        input  o_Tx_Done
    );

    modport slave (
        input  i_Tx_Valid,
        input  i_Tx_Byte,
        output o_Tx_Ready,
        output o_Tx_Serial,
        output o_Tx_Active,
        output o_Tx_Done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing fed from a small valid/ready input FIFO, frames sent back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input logic      i_Clock,
    input logic      i_Reset_n,
    uart_tx_if.slave tx
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = 10;
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // Input FIFO
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ready_c;
    logic          push;
    logic          pop;
    logic [7:0]    head_c;

    assign ready_c = (count_q < FIFO_FULL);
    assign push    = tx.i_Tx_Valid && ready_c;
    assign head_c  = mem[rd_ptr_q];

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset_n && push) mem[wr_ptr_q] <= tx.i_Tx_Byte;
    end

    // Frame sequencer
    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = (cnt_q == BIT_LAST);

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    // Line outputs are registered from the current state, so they lag the state by one cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        serial_d = 1'b1;
        active_d = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head_c;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                serial_d = 1'b0;
                active_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end

            S_DATA: begin
                serial_d = shift_q[idx_q];
                active_d = 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                serial_d = ^shift_q;
                active_d = 1'b1;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
`endif

            S_STOP: begin
                serial_d = 1'b1;
                active_d = 1'b1;
                if (bit_end) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    // Chain straight into the next start bit when a byte is waiting
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head_c;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx.o_Tx_Ready  = ready_c;
    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Done   = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx at CLKS_PER_BIT=8, FIFO_DEPTH=4, with a line-decoding receiver model.
module tb_uart_tx;
    localparam int CPB   = 8;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic i_Clock   = 1'b0;
    logic i_Reset_n = 1'b0;
    int   n_vec;
    int   n_miss;
    int   done_cnt;
    logic [7:0] rx_q [$];

    uart_tx_if tx_bus ();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock  (i_Clock),
        .i_Reset_n(i_Reset_n),
        .tx       (tx_bus)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    // Receiver model: find the falling start edge, sample every bit in its middle
    initial begin : rx_model
        logic       prev;
        logic       cur;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(posedge i_Clock);
            #1;
            cur = tx_bus.o_Tx_Serial;
            if (i_Reset_n === 1'b1 && prev === 1'b1 && cur === 1'b0) begin
                repeat (CPB / 2) step();
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) step();
                    b[i] = tx_bus.o_Tx_Serial;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) step();
`endif
                repeat (CPB) step();
                cur = tx_bus.o_Tx_Serial;
                rx_q.push_back(b);
            end
            prev = cur;
        end
    end

    initial begin : done_counter
        done_cnt = 0;
        forever begin
            @(posedge i_Clock);
            #1;
            if (tx_bus.o_Tx_Done === 1'b1) done_cnt++;
        end
    end

    task automatic wait_fall(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (tx_bus.o_Tx_Serial === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rx(input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (rx_q.size() >= n) break;
            step();
        end
    endtask

    task automatic test_reset();
        tx_bus.i_Tx_Valid = 1'b0;
        tx_bus.i_Tx_Byte  = 8'h00;
        i_Reset_n = 1'b0;
        repeat (3) step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b1 || tx_bus.o_Tx_Ready !== 1'b1 ||
            tx_bus.o_Tx_Active !== 1'b0 || tx_bus.o_Tx_Done !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_values: serial=%b ready=%b active=%b done=%b, expected 1 1 0 0",
                     tx_bus.o_Tx_Serial, tx_bus.o_Tx_Ready, tx_bus.o_Tx_Active, tx_bus.o_Tx_Done);
        end
        i_Reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n_vec++;
            if (tx_bus.o_Tx_Serial !== 1'b1 || tx_bus.o_Tx_Ready !== 1'b1 ||
                tx_bus.o_Tx_Active !== 1'b0 || tx_bus.o_Tx_Done !== 1'b0) begin
                n_miss++;
                $display("FAIL reset_idle cycle %0d: serial=%b ready=%b active=%b done=%b, expected 1 1 0 0",
                         i, tx_bus.o_Tx_Serial, tx_bus.o_Tx_Ready, tx_bus.o_Tx_Active, tx_bus.o_Tx_Done);
            end
        end
    endtask

    task automatic test_single_byte();
        logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tx_bus.i_Tx_Byte  = 8'hA5;
        tx_bus.i_Tx_Valid = 1'b1;
        step();
        tx_bus.i_Tx_Valid = 1'b0;
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b1) begin
            n_miss++;
            $display("FAIL single_lat_e0: serial=%b, expected 1", tx_bus.o_Tx_Serial);
        end
        step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b1) begin
            n_miss++;
            $display("FAIL single_lat_e1: serial=%b, expected 1", tx_bus.o_Tx_Serial);
        end
        step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b0 || tx_bus.o_Tx_Active !== 1'b1) begin
            n_miss++;
            $display("FAIL single_start_e2: serial=%b active=%b, expected 0 1",
                     tx_bus.o_Tx_Serial, tx_bus.o_Tx_Active);
        end
        repeat (CPB / 2) step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b0) begin
            n_miss++;
            $display("FAIL single_start_mid: serial=%b, expected 0", tx_bus.o_Tx_Serial);
        end
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) step();
            n_vec++;
            if (tx_bus.o_Tx_Serial !== exp_bits[i]) begin
                n_miss++;
                $display("FAIL single_bit%0d: serial=%b, expected %b", i, tx_bus.o_Tx_Serial, exp_bits[i]);
            end
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b0) begin
            n_miss++;
            $display("FAIL single_parity: serial=%b, expected 0", tx_bus.o_Tx_Serial);
        end
`endif
        repeat (CPB) step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b1 || tx_bus.o_Tx_Done !== 1'b0) begin
            n_miss++;
            $display("FAIL single_stop_mid: serial=%b done=%b, expected 1 0",
                     tx_bus.o_Tx_Serial, tx_bus.o_Tx_Done);
        end
        repeat (CPB / 2 - 1) step();
        n_vec++;
        if (tx_bus.o_Tx_Done !== 1'b1 || tx_bus.o_Tx_Active !== 1'b1 || tx_bus.o_Tx_Serial !== 1'b1) begin
            n_miss++;
            $display("FAIL single_done_last: done=%b active=%b serial=%b, expected 1 1 1",
                     tx_bus.o_Tx_Done, tx_bus.o_Tx_Active, tx_bus.o_Tx_Serial);
        end
        step();
        n_vec++;
        if (tx_bus.o_Tx_Done !== 1'b0 || tx_bus.o_Tx_Active !== 1'b0 || tx_bus.o_Tx_Serial !== 1'b1) begin
            n_miss++;
            $display("FAIL single_after: done=%b active=%b serial=%b, expected 0 0 1",
                     tx_bus.o_Tx_Done, tx_bus.o_Tx_Active, tx_bus.o_Tx_Serial);
        end
        repeat (4) step();
        n_vec++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
            n_miss++;
            $display("FAIL single_rx: got %0d bytes first=%h, expected 1 byte a5",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        rx_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3] = '{8'h00, 8'hFF, 8'h3C};
        int d0;
        d0 = done_cnt;
        tx_bus.i_Tx_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_bus.i_Tx_Byte = vals[i];
            step();
        end
        tx_bus.i_Tx_Valid = 1'b0;
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b0) begin
            n_miss++;
            $display("FAIL b2b_first_start: serial=%b, expected 0", tx_bus.o_Tx_Serial);
        end
        for (int f = 0; f < 3; f++) begin
            repeat (FRAME - 1) step();
            n_vec++;
            if (tx_bus.o_Tx_Done !== 1'b1) begin
                n_miss++;
                $display("FAIL b2b_done%0d: done=%b, expected 1", f, tx_bus.o_Tx_Done);
            end
            step();
            n_vec++;
            if (f < 2 && (tx_bus.o_Tx_Serial !== 1'b0 || tx_bus.o_Tx_Active !== 1'b1)) begin
                n_miss++;
                $display("FAIL b2b_gap%0d: serial=%b active=%b, expected 0 1",
                         f, tx_bus.o_Tx_Serial, tx_bus.o_Tx_Active);
            end else if (f == 2 && (tx_bus.o_Tx_Serial !== 1'b1 || tx_bus.o_Tx_Active !== 1'b0)) begin
                n_miss++;
                $display("FAIL b2b_end: serial=%b active=%b, expected 1 0",
                         tx_bus.o_Tx_Serial, tx_bus.o_Tx_Active);
            end
        end
        repeat (4) step();
        n_vec++;
        if (done_cnt - d0 != 3) begin
            n_miss++;
            $display("FAIL b2b_done_count: %0d pulses, expected 3", done_cnt - d0);
        end
        n_vec++;
        if (rx_q.size() != 3) begin
            n_miss++;
            $display("FAIL b2b_rx_count: %0d bytes, expected 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (rx_q[i] !== vals[i]) begin
                    n_miss++;
                    $display("FAIL b2b_rx%0d: got %h, expected %h", i, rx_q[i], vals[i]);
                end
            end
        end
        rx_q.delete();
    endtask

    task automatic test_fifo_full();
        logic [7:0] vals [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int   idx;
        logic rdy;
        idx = 0;
        tx_bus.i_Tx_Byte  = vals[0];
        tx_bus.i_Tx_Valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rdy = tx_bus.o_Tx_Ready;
            step();
            if (rdy === 1'b1 && idx < 5) idx++;
            tx_bus.i_Tx_Byte = vals[idx];
        end
        n_vec++;
        if (tx_bus.o_Tx_Ready !== 1'b0) begin
            n_miss++;
            $display("FAIL full_ready: ready=%b, expected 0", tx_bus.o_Tx_Ready);
        end
        tx_bus.i_Tx_Valid = 1'b0;
        n_vec++;
        if (idx != 5) begin
            n_miss++;
            $display("FAIL full_accepts: %0d accepted, expected 5", idx);
        end
        wait_rx(5, 6 * FRAME);
        repeat (8) step();
        n_vec++;
        if (rx_q.size() != 5) begin
            n_miss++;
            $display("FAIL full_rx_count: %0d bytes, expected 5", rx_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_vec++;
                if (rx_q[i] !== vals[i]) begin
                    n_miss++;
                    $display("FAIL full_rx%0d: got %h, expected %h", i, rx_q[i], vals[i]);
                end
            end
        end
        n_vec++;
        if (tx_bus.o_Tx_Ready !== 1'b1 || tx_bus.o_Tx_Active !== 1'b0) begin
            n_miss++;
            $display("FAIL full_drained: ready=%b active=%b, expected 1 0",
                     tx_bus.o_Tx_Ready, tx_bus.o_Tx_Active);
        end
        rx_q.delete();
    endtask

    task automatic test_push_on_pop();
        logic [7:0] vals [3] = '{8'hA1, 8'hB2, 8'hC3};
        tx_bus.i_Tx_Byte  = vals[0];
        tx_bus.i_Tx_Valid = 1'b1;
        step();
        tx_bus.i_Tx_Valid = 1'b0;
        repeat (2) step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b0) begin
            n_miss++;
            $display("FAIL pop_start: serial=%b, expected 0", tx_bus.o_Tx_Serial);
        end
        tx_bus.i_Tx_Byte  = vals[1];
        tx_bus.i_Tx_Valid = 1'b1;
        step();
        tx_bus.i_Tx_Valid = 1'b0;
        repeat (FRAME - 3) step();
        tx_bus.i_Tx_Byte  = vals[2];
        tx_bus.i_Tx_Valid = 1'b1;
        step();
        tx_bus.i_Tx_Valid = 1'b0;
        n_vec++;
        if (tx_bus.o_Tx_Done !== 1'b1 || tx_bus.o_Tx_Ready !== 1'b1) begin
            n_miss++;
            $display("FAIL pop_same_edge: done=%b ready=%b, expected 1 1",
                     tx_bus.o_Tx_Done, tx_bus.o_Tx_Ready);
        end
        step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b0) begin
            n_miss++;
            $display("FAIL pop_next_start: serial=%b, expected 0", tx_bus.o_Tx_Serial);
        end
        wait_rx(3, 3 * FRAME);
        repeat (8) step();
        n_vec++;
        if (rx_q.size() != 3) begin
            n_miss++;
            $display("FAIL pop_rx_count: %0d bytes, expected 3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (rx_q[i] !== vals[i]) begin
                    n_miss++;
                    $display("FAIL pop_rx%0d: got %h, expected %h", i, rx_q[i], vals[i]);
                end
            end
        end
        rx_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        bit seen;
        tx_bus.i_Tx_Byte  = 8'h52;
        tx_bus.i_Tx_Valid = 1'b1;
        step();
        tx_bus.i_Tx_Valid = 1'b0;
        wait_fall(10, seen);
        n_vec++;
        if (!seen) begin
            n_miss++;
            $display("FAIL mid_first_start: no start bit within 10 cycles, expected one");
        end
        tx_bus.i_Tx_Byte  = 8'h77;
        tx_bus.i_Tx_Valid = 1'b1;
        step();
        tx_bus.i_Tx_Valid = 1'b0;
        repeat (4 * CPB + 2 - 1) step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b0 || tx_bus.o_Tx_Ready !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_bit3: serial=%b ready=%b, expected 0 1",
                     tx_bus.o_Tx_Serial, tx_bus.o_Tx_Ready);
        end
        i_Reset_n = 1'b0;
        step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b1 || tx_bus.o_Tx_Active !== 1'b0 ||
            tx_bus.o_Tx_Ready !== 1'b1 || tx_bus.o_Tx_Done !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_reset: serial=%b active=%b ready=%b done=%b, expected 1 0 1 0",
                     tx_bus.o_Tx_Serial, tx_bus.o_Tx_Active, tx_bus.o_Tx_Ready, tx_bus.o_Tx_Done);
        end
        i_Reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            n_vec++;
            if (tx_bus.o_Tx_Serial !== 1'b1 || tx_bus.o_Tx_Active !== 1'b0) begin
                n_miss++;
                $display("FAIL mid_flushed cycle %0d: serial=%b active=%b, expected 1 0",
                         i, tx_bus.o_Tx_Serial, tx_bus.o_Tx_Active);
            end
        end
        rx_q.delete();
        tx_bus.i_Tx_Byte  = 8'hC3;
        tx_bus.i_Tx_Valid = 1'b1;
        step();
        tx_bus.i_Tx_Valid = 1'b0;
        repeat (2) step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_new_start: serial=%b, expected 0", tx_bus.o_Tx_Serial);
        end
        wait_rx(1, 2 * FRAME);
        repeat (8) step();
        n_vec++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hC3) begin
            n_miss++;
            $display("FAIL mid_new_rx: got %0d bytes first=%h, expected 1 byte c3",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        rx_q.delete();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        bit seen;
        tx_bus.i_Tx_Byte  = 8'h07;
        tx_bus.i_Tx_Valid = 1'b1;
        step();
        tx_bus.i_Tx_Valid = 1'b0;
        wait_fall(10, seen);
        n_vec++;
        if (!seen) begin
            n_miss++;
            $display("FAIL par_start: no start bit within 10 cycles, expected one");
        end
        repeat (9 * CPB + CPB / 2) step();
        n_vec++;
        if (tx_bus.o_Tx_Serial !== 1'b1) begin
            n_miss++;
            $display("FAIL par_bit: serial=%b, expected 1", tx_bus.o_Tx_Serial);
        end
        repeat (CPB + CPB / 2 - 1) step();
        n_vec++;
        if (tx_bus.o_Tx_Done !== 1'b1) begin
            n_miss++;
            $display("FAIL par_done_at_87: done=%b, expected 1", tx_bus.o_Tx_Done);
        end
        step();
        n_vec++;
        if (tx_bus.o_Tx_Active !== 1'b0 || tx_bus.o_Tx_Serial !== 1'b1) begin
            n_miss++;
            $display("FAIL par_len88: active=%b serial=%b, expected 0 1",
                     tx_bus.o_Tx_Active, tx_bus.o_Tx_Serial);
        end
        repeat (4) step();
        rx_q.delete();
    endtask
`endif

    initial begin
        n_vec  = 0;
        n_miss = 0;
        tx_bus.i_Tx_Valid = 1'b0;
        tx_bus.i_Tx_Byte  = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_full();
        test_push_on_pop();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
